bow_tx_frame_buf: RTL and testbench

//  Parametrised BoW transmit framer: APB-style write port loads data words plus fec/aux sideband bits into a circular buffer.

---
 rtl/bow_tx_frame_buf_if.sv | 25 ++
 rtl/bow_tx_frame_buf.sv | 216 +++++++++++++++++++++
 tb/tb_bow_tx_frame_buf.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bow_tx_frame_buf_if.sv
// APB-style write/status port of the BoW transmit framer: word and sideband
// bits flow master -> slave, ready/read data/error flow back.
interface bow_tx_frame_buf_if #(
    parameter int DATA_W = 16
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              fec_in;
    logic              aux_in;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, pwdata, fec_in, aux_in,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, pwdata, fec_in, aux_in,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/bow_tx_frame_buf.sv
// BoW transmit framer: circular word buffer filled over APB, drained to the lane in
// SOF/EOF-delimited frames with PRBS training fill. Define BOW_TX_PARITY_EN to add tx_parity.
module bow_tx_frame_buf #(
    parameter int          DATA_W     = 16,
    parameter int          DEPTH      = 32,
    parameter int          FRAME_LEN  = 32,
    parameter int          GAP_CYCLES = 2,
    parameter logic [15:0] PRBS_SEED  = 16'hACE1
) (
    input  logic                       txclk,
    input  logic                       presetn,
    bow_tx_frame_buf_if.slave          apb,
    input  logic                       rx_ready,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_valid,
    output logic                       tx_sof,
    output logic                       tx_eof,
    output logic                       fec_out,
    output logic                       aux_out,
`ifdef BOW_TX_PARITY_EN
    output logic                       tx_parity,
`endif
    output logic [$clog2(DEPTH+1)-1:0] buf_level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int GAP_W = 4;
    localparam int REP   = DATA_W / 16;

    typedef enum logic [1:0] {
        S_TRAIN,
        S_SEND,
        S_PAUSE,
        S_GAP
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              fec;
        logic              aux;
    } entry_t;

    function automatic logic [15:0] prbs_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    entry_t             mem_q [DEPTH];
    entry_t             rd_word;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   sent_q, sent_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [15:0]        lfsr_q, lfsr_d;

    logic [DATA_W-1:0]  tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               tx_sof_q, tx_sof_d;
    logic               tx_eof_q, tx_eof_d;
    logic               fec_q, fec_d;
    logic               aux_q, aux_d;

    logic               access;
    logic               full;
    logic               rd_en;
    logic               wr_en;

    // A word leaving on this edge frees a slot, so a full buffer can still take a write.
    assign access      = apb.psel & apb.penable;
    assign full        = (level_q == LVL_W'(DEPTH));
    assign wr_en       = access & apb.pwrite & (~full | rd_en);
    assign apb.pready  = access & (~apb.pwrite | ~full | rd_en);
    assign apb.prdata  = (access & ~apb.pwrite) ? {1'b0, (DATA_W-1)'(level_q)} : '0;
    assign apb.pslverr = 1'b0;

    assign rd_word = mem_q[rptr_q];

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d    = state_q;
        sent_d     = sent_q;
        gap_d      = gap_q;
        lfsr_d     = lfsr_q;
        rd_en      = 1'b0;
        tx_data_d  = tx_data_q;
        tx_valid_d = 1'b0;
        tx_sof_d   = 1'b0;
        tx_eof_d   = 1'b0;
        fec_d      = 1'b0;
        aux_d      = 1'b0;

        case (state_q)
            S_TRAIN: rd_en = rx_ready && (level_q >= LVL_W'(FRAME_LEN));
            S_SEND, S_PAUSE: begin
                rd_en = rx_ready;
                if (!rx_ready) begin
                    state_d = S_PAUSE;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = S_TRAIN;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = S_TRAIN;
        endcase

        if (rd_en) begin
            tx_valid_d = 1'b1;
            tx_sof_d   = (state_q == S_TRAIN);
            tx_data_d  = rd_word.data;
            fec_d      = rd_word.fec;
            aux_d      = rd_word.aux;
            tx_eof_d   = (state_q == S_TRAIN) ? (FRAME_LEN == 1)
                                              : (sent_q == CNT_W'(FRAME_LEN - 1));
            if (tx_eof_d) begin
                sent_d  = '0;
                state_d = (GAP_CYCLES > 0) ? S_GAP : S_TRAIN;
            end else begin
                sent_d  = (state_q == S_TRAIN) ? CNT_W'(1) : sent_q + 1'b1;
                state_d = S_SEND;
            end
        end else begin
            // Lane is idle or paused: the LFSR keeps running, but a paused lane holds its last word.
            lfsr_d = prbs_step(lfsr_q);
            if (state_q == S_TRAIN || state_q == S_GAP) begin
                tx_data_d = {REP{lfsr_q}};
            end
        end
    end

    always_comb begin
        wptr_d  = wr_en ? ptr_inc(wptr_q) : wptr_q;
        rptr_d  = rd_en ? ptr_inc(rptr_q) : rptr_q;
        level_d = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge txclk or negedge presetn) begin
        if (!presetn) begin
            state_q    <= S_TRAIN;
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            sent_q     <= '0;
            gap_q      <= '0;
            lfsr_q     <= PRBS_SEED;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            tx_sof_q   <= 1'b0;
            tx_eof_q   <= 1'b0;
            fec_q      <= 1'b0;
            aux_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            level_q    <= level_d;
            sent_q     <= sent_d;
            gap_q      <= gap_d;
            lfsr_q     <= lfsr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            tx_sof_q   <= tx_sof_d;
            tx_eof_q   <= tx_eof_d;
            fec_q      <= fec_d;
            aux_q      <= aux_d;
        end
    end

    // NOTE: the buffer array has no reset; zeroed pointers and level make stale entries unreachable.
    always_ff @(posedge txclk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= '{data: apb.pwdata, fec: apb.fec_in, aux: apb.aux_in};
        end
    end

`ifdef BOW_TX_PARITY_EN
    logic tx_parity_q;

    always_ff @(posedge txclk or negedge presetn) begin
        if (!presetn) begin
            tx_parity_q <= 1'b0;
        end else begin
            tx_parity_q <= ^{tx_data_d, fec_d, aux_d};
        end
    end

    assign tx_parity = tx_parity_q;
`endif

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign tx_sof    = tx_sof_q;
    assign tx_eof    = tx_eof_q;
    assign fec_out   = fec_q;
    assign aux_out   = aux_q;
    assign buf_level = level_q;

endmodule

// File: tb/tb_bow_tx_frame_buf.sv
// Randomised self-checking bench for bow_tx_frame_buf: a queue-based frame model
// predicts every lane output, the buffer level and the APB ready/status each cycle.
module tb_bow_tx_frame_buf;

    localparam int          DATA_W     = 16;
    localparam int          DEPTH      = 32;
    localparam int          FRAME_LEN  = 32;
    localparam int          GAP_CYCLES = 2;
    localparam logic [15:0] SEED       = 16'hACE1;
    localparam int          LVL_W      = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [15:0] d;
        logic        f;
        logic        a;
    } word_t;

    logic              clk = 1'b0;
    logic              presetn;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid, tx_sof, tx_eof, fec_out, aux_out;
    logic [LVL_W-1:0]  buf_level;
`ifdef BOW_TX_PARITY_EN
    logic              tx_parity;
`endif

    always #5 clk = ~clk;

    bow_tx_frame_buf_if #(.DATA_W(DATA_W)) bif ();

    bow_tx_frame_buf #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN),
        .GAP_CYCLES(GAP_CYCLES),
        .PRBS_SEED (SEED)
    ) dut (
        .txclk    (clk),
        .presetn  (presetn),
        .apb      (bif),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_sof   (tx_sof),
        .tx_eof   (tx_eof),
        .fec_out  (fec_out),
        .aux_out  (aux_out),
`ifdef BOW_TX_PARITY_EN
        .tx_parity(tx_parity),
`endif
        .buf_level(buf_level)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: the buffer is a queue, a frame is "words still owed", the gap a countdown.
    word_t       q[$];
    int          frame_left;
    int          gap_left;
    logic [15:0] lfsr;
    logic [15:0] e_data;
    logic        e_valid, e_sof, e_eof, e_fec, e_aux;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    task automatic model_reset();
        q.delete();
        frame_left = 0;
        gap_left   = 0;
        lfsr       = SEED;
        e_data     = '0;
        e_valid    = 1'b0;
        e_sof      = 1'b0;
        e_eof      = 1'b0;
        e_fec      = 1'b0;
        e_aux      = 1'b0;
    endtask

    function automatic bit model_sends(input bit rx);
        if (frame_left > 0) return rx;
        if (gap_left > 0)   return 1'b0;
        return rx && (q.size() >= FRAME_LEN);
    endfunction

    task automatic model_edge(input bit rx, input bit acc, input word_t w);
        word_t r;
        bit    send_now;
        send_now = model_sends(rx);
        e_valid  = 1'b0;
        e_sof    = 1'b0;
        e_eof    = 1'b0;
        e_fec    = 1'b0;
        e_aux    = 1'b0;
        if (send_now) begin
            r       = q.pop_front();
            e_valid = 1'b1;
            e_data  = r.d;
            e_fec   = r.f;
            e_aux   = r.a;
            if (frame_left == 0) begin
                e_sof      = 1'b1;
                frame_left = FRAME_LEN;
            end
            frame_left--;
            e_eof = (frame_left == 0);
            if (e_eof) gap_left = GAP_CYCLES;
        end else if (frame_left == 0) begin
            if (gap_left > 0) gap_left--;
            e_data = lfsr;
        end
        if (!e_valid) lfsr = lfsr_next(lfsr);
        if (acc) q.push_back(w);
    endtask

    task automatic check_outputs();
        check("tx_data",   tx_data,   e_data);
        check("tx_valid",  tx_valid,  e_valid);
        check("tx_sof",    tx_sof,    e_sof);
        check("tx_eof",    tx_eof,    e_eof);
        check("fec_out",   fec_out,   e_fec);
        check("aux_out",   aux_out,   e_aux);
        check("buf_level", buf_level, q.size());
`ifdef BOW_TX_PARITY_EN
        check("tx_parity", tx_parity, ^{e_data, e_fec, e_aux});
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},   tx_data,     0);
        check({tag, "_valid"},  tx_valid,    0);
        check({tag, "_sof"},    tx_sof,      0);
        check({tag, "_eof"},    tx_eof,      0);
        check({tag, "_fec"},    fec_out,     0);
        check({tag, "_aux"},    aux_out,     0);
        check({tag, "_level"},  buf_level,   0);
        check({tag, "_pready"}, bif.pready,  0);
        check({tag, "_prdata"}, bif.prdata,  0);
        check({tag, "_slverr"}, bif.pslverr, 0);
`ifdef BOW_TX_PARITY_EN
        check({tag, "_parity"}, tx_parity,   0);
`endif
    endtask

    // One clock: drive after the falling edge, check ready/status, step the model, check outputs.
    task automatic cycle(input bit do_wr, input word_t w, input bit do_rd, input bit rx, output bit acc);
        bit e_ready;
        bif.psel    = do_wr | do_rd;
        bif.penable = do_wr | do_rd;
        bif.pwrite  = do_wr;
        bif.pwdata  = w.d;
        bif.fec_in  = w.f;
        bif.aux_in  = w.a;
        rx_ready    = rx;
        #1;
        e_ready = (do_wr || do_rd) && (!do_wr || q.size() < DEPTH || model_sends(rx));
        check("pready", bif.pready, e_ready);
        if (do_rd) check("prdata", bif.prdata, q.size());
        acc = do_wr && e_ready;
        @(posedge clk);
        model_edge(rx, acc, w);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit rx);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, rx, acc);
    endtask

    task automatic write_word(input logic [15:0] d, input bit f, input bit a, input bit rx);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 200) begin
            cycle(1'b1, '{d: d, f: f, a: a}, 1'b0, rx, acc);
            tries++;
        end
        check("write_accepted", acc, 1);
    endtask

    initial begin
        bit          acc;
        bit          pend;
        word_t       pw;
        int          vcnt;
        int          scnt;
        int          drop;
        bit          rx;
        bit          do_rd;

        presetn     = 1'b0;
        rx_ready    = 1'b0;
        bif.psel    = 1'b0;
        bif.penable = 1'b0;
        bif.pwrite  = 1'b0;
        bif.pwdata  = '0;
        bif.fec_in  = 1'b0;
        bif.aux_in  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        presetn = 1'b1;

        idle(1, 1'b0);
        check("prbs_first", tx_data, 16'hACE1);
        idle(5, 1'b0);

        // Full frame 0x0001..0x0020, fec on odd index, then the inter-frame gap.
        for (int i = 1; i <= 32; i++) write_word(16'(i), i[0], 1'b0, 1'b0);
        check("fill_level", buf_level, 32);
        vcnt = 0;
        for (int i = 0; i < 36; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, acc);
            if (tx_valid) vcnt++;
        end
        check("frame_words", vcnt, FRAME_LEN);

        // Pause after word 10 for 5 cycles.
        for (int i = 1; i <= 32; i++) write_word(16'h0100 + 16'(i), 1'b0, i[1], 1'b0);
        scnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, acc);
            if (tx_sof) scnt++;
        end
        idle(5, 1'b0);
        check("pause_hold", tx_data, 16'h010A);
        check("pause_valid", tx_valid, 0);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1, acc);
            if (tx_sof) scnt++;
        end
        check("pause_one_sof", scnt, 1);

        // Back-pressure: a 33rd write stalls until the first word of the frame leaves.
        for (int i = 1; i <= 32; i++) write_word(16'h0200 + 16'(i), i[0], 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, '{d: 16'h02FF, f: 1'b1, a: 1'b0}, 1'b0, 1'b0, acc);
        cycle(1'b1, '{d: 16'h02FF, f: 1'b1, a: 1'b0}, 1'b0, 1'b1, acc);
        check("bp_level", buf_level, 32);
        idle(40, 1'b1);

        // Random fill/drain with bursts of back-pressure and status reads.
        pend = 1'b0;
        pw   = '0;
        drop = 0;
        for (int c = 0; c < 3000; c++) begin
            if (drop > 0) begin
                rx = 1'b0;
                drop--;
            end else if ($urandom_range(0, 39) == 0) begin
                rx   = 1'b0;
                drop = $urandom_range(1, 8);
            end else begin
                rx = ($urandom_range(0, 9) != 0);
            end
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend = 1'b1;
                pw   = '{d: 16'($urandom), f: 1'($urandom), a: 1'($urandom)};
            end
            do_rd = !pend && ($urandom_range(0, 3) == 0);
            cycle(pend, pw, do_rd, rx, acc);
            if (acc) pend = 1'b0;
        end

        // Asynchronous reset in the middle of a frame.
        idle(80, 1'b1);
        while (q.size() < DEPTH) write_word(16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        idle(8, 1'b1);
        #2;
        presetn = 1'b0;
        rx_ready = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        presetn = 1'b1;
        idle(1, 1'b1);
        check("post_reset_prbs", tx_data, 16'hACE1);
        idle(4, 1'b1);

        // Clean frame after reset, with concurrent writes during the drain.
        for (int i = 1; i <= 32; i++) write_word(16'h0300 + 16'(i), i[0], 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, '{d: 16'h0400 + 16'(i), f: 1'b0, a: 1'b1}, 1'b0, 1'b1, acc);
        idle(40, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
